// File: rtl/counter_ctrl_pkg.sv
// Shared types and default sizes for the programmable interval timer.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } ctrl_state_t;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_PRESC_W = 8;

endpackage

// File: rtl/tick_prescaler.sv
// Divide-by-(prescale+1) enable generator; counts only while run is high.
module tick_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               clr,
    input  logic               run,
    input  logic [PRESC_W-1:0] prescale,
    output logic               en
);

    logic [PRESC_W-1:0] cnt_q;
    logic [PRESC_W-1:0] cnt_d;

    assign en = run && (cnt_q == prescale);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = en ? '0 : cnt_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/counter_timer_ctrl.sv
// Interval timer: sequencing FSM plus counter datapath, with one-shot/periodic
// expiry, pause/resume and a sticky interrupt. All outputs are registered.
module counter_timer_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               resume,
    input  logic               mode_periodic,
    input  logic [WIDTH-1:0]   period,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               irq_clr,
    output logic [WIDTH-1:0]   count,
    output logic               busy,
    output logic               tick,
    output logic               irq,
    output ctrl_state_t        dbg_state
);

    ctrl_state_t        state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   period_q, period_d;
    logic [PRESC_W-1:0] prescale_q, prescale_d;
    logic               mode_q, mode_d;
    logic               tick_q, tick_d;
    logic               irq_q, irq_d;

    logic stop_v, pause_v, resume_v;
    logic presc_clr, presc_run, en, expiry;

    // Commands that are meaningless in the current state are dropped here,
    // so a lower-priority command can still act in the same cycle.
    always_comb begin
        stop_v    = stop && (state_q != IDLE);
        pause_v   = pause && (state_q == RUN);
        resume_v  = resume && (state_q == PAUSED);
        presc_clr = stop_v || start;
        presc_run = (state_q == RUN) && !stop_v && !start && !pause_v;
    end

    tick_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (presc_clr),
        .run      (presc_run),
        .prescale (prescale_q),
        .en       (en)
    );

    assign expiry = presc_run && en && (count_q == period_q);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        period_d   = period_q;
        prescale_d = prescale_q;
        mode_d     = mode_q;
        tick_d     = 1'b0;
        irq_d      = irq_q;

        if (stop_v) begin
            state_d = IDLE;
            count_d = '0;
        end else if (start) begin
            state_d    = RUN;
            count_d    = '0;
            period_d   = period;
            prescale_d = prescale;
            mode_d     = mode_periodic;
        end else if (pause_v) begin
            state_d = PAUSED;
        end else if (resume_v) begin
            state_d = RUN;
        end else if (presc_run && en) begin
            if (expiry) begin
                count_d = '0;
                tick_d  = 1'b1;
                if (!mode_q) begin
                    state_d = IDLE;
                end
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end

        // Expiry wins over a simultaneous clear.
        if (expiry) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            count_q    <= '0;
            period_q   <= '0;
            prescale_q <= '0;
            mode_q     <= 1'b0;
            tick_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            period_q   <= period_d;
            prescale_q <= prescale_d;
            mode_q     <= mode_d;
            tick_q     <= tick_d;
            irq_q      <= irq_d;
        end
    end

    assign count     = count_q;
    assign busy      = (state_q != IDLE);
    assign tick      = tick_q;
    assign irq       = irq_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// Randomised and directed bench for counter_timer_ctrl, checked against an
// elapsed-clock arithmetic model through an expected-value queue.
module tb_counter_timer_ctrl;
    import counter_ctrl_pkg::*;

    localparam int WIDTH   = 16;
    localparam int PRESC_W = 8;
    localparam int EW      = WIDTH + 3;

    logic               clk;
    logic               rstn;
    logic               start, stop, pause, resume, mode_periodic, irq_clr;
    logic [WIDTH-1:0]   period;
    logic [PRESC_W-1:0] prescale;
    logic [WIDTH-1:0]   count;
    logic               busy, tick, irq;
    ctrl_state_t        dbg_state;

    counter_timer_ctrl #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .stop          (stop),
        .pause         (pause),
        .resume        (resume),
        .mode_periodic (mode_periodic),
        .period        (period),
        .prescale      (prescale),
        .irq_clr       (irq_clr),
        .count         (count),
        .busy          (busy),
        .tick          (tick),
        .irq           (irq),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // ---------------- reference model ----------------
    // Timer position is tracked as clocks spent actively running since start;
    // count and expiry follow from division by the configured interval.
    logic               want_rstn;
    logic               cfg_mode;
    logic [WIDTH-1:0]   cfg_period;
    logic [PRESC_W-1:0] cfg_presc;

    logic   m_running, m_paused, m_periodic, m_irq, m_tick;
    longint m_clk, m_period, m_presc;

    function automatic logic [EW-1:0] model_out();
        longint c;
        c = (m_running || m_paused) ? (m_clk / (m_presc + 1)) % (m_period + 1) : 0;
        return {WIDTH'(c), (m_running || m_paused), m_tick, m_irq};
    endfunction

    task automatic model_step(input logic st, sp, pa, re, ic);
        logic expired;
        expired = 1'b0;
        m_tick  = 1'b0;
        if (!rstn) begin
            m_running = 0; m_paused = 0; m_periodic = 0; m_irq = 0;
            m_clk = 0; m_period = 0; m_presc = 0;
            return;
        end
        if (sp && (m_running || m_paused)) begin
            m_running = 0; m_paused = 0; m_clk = 0;
        end else if (st) begin
            m_running = 1; m_paused = 0; m_clk = 0;
            m_period = longint'(cfg_period); m_presc = longint'(cfg_presc);
            m_periodic = cfg_mode;
        end else if (pa && m_running) begin
            m_running = 0; m_paused = 1;
        end else if (re && m_paused) begin
            m_running = 1; m_paused = 0;
        end else if (m_running) begin
            m_clk = m_clk + 1;
            if (m_clk % ((m_period + 1) * (m_presc + 1)) == 0) begin
                expired = 1'b1;
                m_tick  = 1'b1;
                if (!m_periodic) begin
                    m_running = 0; m_clk = 0;
                end
            end
        end
        if (expired) m_irq = 1'b1;
        else if (ic) m_irq = 1'b0;
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic st, sp, pa, re, ic);
        @(negedge clk);
        rstn          = want_rstn;
        start         = st;
        stop          = sp;
        pause         = pa;
        resume        = re;
        irq_clr       = ic;
        mode_periodic = cfg_mode;
        period        = cfg_period;
        prescale      = cfg_presc;
        model_step(st, sp, pa, re, ic);
        exp_q.push_back(model_out());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input logic md, input logic [WIDTH-1:0] per, input logic [PRESC_W-1:0] ps);
        cfg_mode = md; cfg_period = per; cfg_presc = ps;
    endtask

    task automatic check_now(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2;
        rstn      = 1'b0;
        want_rstn = 1'b0;
        #1;
        check_now("async_rst_count", count, '0);
        check_now("async_rst_busy", WIDTH'(busy), '0);
        check_now("async_rst_irq", WIDTH'(irq), '0);
        check_now("async_rst_tick", WIDTH'(tick), '0);
        m_running = 0; m_paused = 0; m_irq = 0; m_clk = 0;
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic [EW-1:0] e;
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({count, busy, tick, irq} !== e) begin
                n_fail++;
                $display("FAIL out cyc%0d: got count=%h busy=%b tick=%b irq=%b required count=%h busy=%b tick=%b irq=%b",
                         cyc, count, busy, tick, irq, e[EW-1:3], e[2], e[1], e[0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rstn = 1'b0; want_rstn = 1'b0;
        start = 0; stop = 0; pause = 0; resume = 0; irq_clr = 0;
        mode_periodic = 0; period = '0; prescale = '0;
        cfg(0, '0, '0);
        m_running = 0; m_paused = 0; m_periodic = 0; m_irq = 0; m_tick = 0;
        m_clk = 0; m_period = 0; m_presc = 0;

        idle(3);
        want_rstn = 1'b1;
        idle(2);

        // one-shot, no prescale
        cfg(0, 16'd3, 8'd0);
        drive(1, 0, 0, 0, 0);
        idle(6);

        // periodic with prescale, irq held until cleared
        cfg(1, 16'd2, 8'd1);
        drive(1, 0, 0, 0, 0);
        idle(18);
        drive(0, 0, 0, 0, 1);
        idle(3);
        drive(0, 1, 0, 0, 0);
        idle(2);

        // pause / resume
        cfg(0, 16'd10, 8'd0);
        drive(1, 0, 0, 0, 0);
        idle(4);
        drive(0, 0, 1, 0, 0);
        idle(5);
        drive(0, 0, 0, 1, 0);
        idle(12);

        // stop colliding with expiry
        cfg(0, 16'd3, 8'd0);
        drive(0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0);
        idle(3);
        drive(0, 1, 0, 0, 0);
        idle(2);

        // irq_clr colliding with expiry
        drive(1, 0, 0, 0, 0);
        idle(3);
        drive(0, 0, 0, 0, 1);
        idle(2);

        // restart while paused with a new period
        cfg(0, 16'd10, 8'd0);
        drive(1, 0, 0, 0, 0);
        idle(4);
        drive(0, 0, 1, 0, 0);
        idle(2);
        cfg(0, 16'd5, 8'd0);
        drive(1, 0, 0, 0, 0);
        idle(8);

        // period 0: expiry every cycle
        cfg(1, 16'd0, 8'd0);
        drive(1, 0, 0, 0, 0);
        idle(5);
        drive(0, 1, 0, 0, 0);

        // random commands with random configurations
        for (int i = 0; i < 2500; i++) begin
            logic st, sp, pa, re, ic;
            st = ($urandom_range(0, 29) == 0);
            sp = ($urandom_range(0, 59) == 0);
            pa = ($urandom_range(0, 19) == 0);
            re = ($urandom_range(0, 9) == 0);
            ic = ($urandom_range(0, 14) == 0);
            if (st) cfg(1'($urandom_range(0, 1)), WIDTH'($urandom_range(0, 12)), PRESC_W'($urandom_range(0, 3)));
            drive(st, sp, pa, re, ic);
        end

        // asynchronous reset mid-run, then remain idle after release
        cfg(1, 16'd20, 8'd0);
        drive(1, 0, 0, 0, 0);
        idle(5);
        async_reset();
        idle(2);
        want_rstn = 1'b1;
        idle(4);

        // full-range period, one-shot
        cfg(0, 16'hFFFF, 8'd0);
        drive(1, 0, 0, 0, 0);
        idle(65538);

        repeat (3) @(posedge clk);
        #2;
        check_now("queue_drained", WIDTH'(exp_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
